apb_cmd_master: RTL and testbench

- APB initiator: the requester end of the APB interface our peripheral slaves (TX/RX protocol engines) already implement.
- Accepts register-access commands from an internal controller over a valid/ready interface and buffers them in a small FIFO.
- Executes each command as an APB SETUP/ACCESS transfer, honouring PREADY wait states, and returns a per-command response with read data.
- Replaces hand-driven bus sequencing, e.g. config write, TX data burst, start command.

---
 rtl/apb_cmd_master.sv | 192 +++++++++++++++++++
 tb/tb_apb_cmd_master.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_cmd_master.sv
// APB initiator: queues register-access commands in a small FIFO and runs each one as a SETUP/ACCESS transfer.
// Define APB_TIMEOUT_EN to abort ACCESS phases that wait TIMEOUT_CYCLES cycles without PREADY.
module apb_cmd_master #(
    parameter int ADDRESSWIDTH   = 3,
    parameter int DATAWIDTH      = 16,
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                    PCLK,
    input  logic                    PRESETn,
    input  logic                    cmd_valid_i,
    output logic                    cmd_ready_o,
    input  logic                    cmd_write_i,
    input  logic [ADDRESSWIDTH-1:0] cmd_addr_i,
    input  logic [DATAWIDTH-1:0]    cmd_wdata_i,
    output logic                    rsp_valid_o,
    output logic [DATAWIDTH-1:0]    rsp_rdata_o,
    output logic                    rsp_err_o,
    output logic                    busy_o,
    output logic [ADDRESSWIDTH-1:0] PADDR_o,
    output logic [DATAWIDTH-1:0]    PWDATA_o,
    output logic                    PWRITE_o,
    output logic                    PSELx_o,
    output logic                    PENABLE_o,
    input  logic [DATAWIDTH-1:0]    PRDATA_i,
    input  logic                    PREADY_i
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("apb_cmd_master: FIFO_DEPTH must be a power of two >= 2 and TIMEOUT_CYCLES >= 1");
    end

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

    state_t state, state_nxt;

    logic [ADDRESSWIDTH-1:0] fifo_addr  [FIFO_DEPTH];
    logic [DATAWIDTH-1:0]    fifo_wdata [FIFO_DEPTH];
    logic                    fifo_write [FIFO_DEPTH];
    logic [PTR_W-1:0]        wr_ptr, rd_ptr;
    logic [CNT_W-1:0]        count, count_nxt;
    logic                    push, pop, fifo_empty;
    logic                    timeout;

    logic                    psel_nxt, penable_nxt, pwrite_nxt, rsp_valid_nxt;
    logic [ADDRESSWIDTH-1:0] paddr_nxt;
    logic [DATAWIDTH-1:0]    pwdata_nxt, rsp_rdata_nxt;

    assign cmd_ready_o = (count != CNT_W'(FIFO_DEPTH));
    assign push        = cmd_valid_i && cmd_ready_o;
    assign fifo_empty  = (count == '0);

    // Command storage carries no reset; only pointers and count define its contents.
    always_ff @(posedge PCLK) begin
        if (push) begin
            fifo_addr[wr_ptr]  <= cmd_addr_i;
            fifo_wdata[wr_ptr] <= cmd_wdata_i;
            fifo_write[wr_ptr] <= cmd_write_i;
        end
    end

    always_comb begin
        count_nxt = count;
        case ({push, pop})
            2'b10:   count_nxt = count + CNT_W'(1);
            2'b01:   count_nxt = count - CNT_W'(1);
            default: count_nxt = count;
        endcase
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count_nxt;
        end
    end

`ifdef APB_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TO_W-1:0] to_cnt;

    // Abort on the edge that would bring the wait count up to TIMEOUT_CYCLES.
    assign timeout = (state == ACCESS) && !PREADY_i && (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            to_cnt    <= '0;
            rsp_err_o <= 1'b0;
        end else begin
            if (state == SETUP)
                to_cnt <= '0;
            else if (state == ACCESS && !PREADY_i)
                to_cnt <= to_cnt + TO_W'(1);
            rsp_err_o <= timeout;
        end
    end
`else
    assign timeout   = 1'b0;
    assign rsp_err_o = 1'b0;
`endif

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (!fifo_empty) state_nxt = SETUP;
            SETUP:   state_nxt = ACCESS;
            ACCESS: begin
                if (PREADY_i)     state_nxt = fifo_empty ? IDLE : SETUP;
                else if (timeout) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        pop           = 1'b0;
        psel_nxt      = PSELx_o;
        penable_nxt   = PENABLE_o;
        paddr_nxt     = PADDR_o;
        pwdata_nxt    = PWDATA_o;
        pwrite_nxt    = PWRITE_o;
        rsp_valid_nxt = 1'b0;
        rsp_rdata_nxt = rsp_rdata_o;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    pop         = 1'b1;
                    psel_nxt    = 1'b1;
                    penable_nxt = 1'b0;
                end
            end
            SETUP: penable_nxt = 1'b1;
            ACCESS: begin
                if (PREADY_i) begin
                    rsp_valid_nxt = 1'b1;
                    rsp_rdata_nxt = PWRITE_o ? '0 : PRDATA_i;
                    penable_nxt   = 1'b0;
                    if (!fifo_empty) pop = 1'b1;
                    else             psel_nxt = 1'b0;
                end else if (timeout) begin
                    rsp_valid_nxt = 1'b1;
                    rsp_rdata_nxt = '0;
                    psel_nxt      = 1'b0;
                    penable_nxt   = 1'b0;
                end
            end
            default: ;
        endcase
        if (pop) begin
            paddr_nxt  = fifo_addr[rd_ptr];
            pwdata_nxt = fifo_wdata[rd_ptr];
            pwrite_nxt = fifo_write[rd_ptr];
        end
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            PSELx_o     <= 1'b0;
            PENABLE_o   <= 1'b0;
            PADDR_o     <= '0;
            PWDATA_o    <= '0;
            PWRITE_o    <= 1'b0;
            rsp_valid_o <= 1'b0;
            rsp_rdata_o <= '0;
            busy_o      <= 1'b0;
        end else begin
            PSELx_o     <= psel_nxt;
            PENABLE_o   <= penable_nxt;
            PADDR_o     <= paddr_nxt;
            PWDATA_o    <= pwdata_nxt;
            PWRITE_o    <= pwrite_nxt;
            rsp_valid_o <= rsp_valid_nxt;
            rsp_rdata_o <= rsp_rdata_nxt;
            busy_o      <= (state_nxt != IDLE) || (count_nxt != '0);
        end
    end

endmodule

// File: tb/tb_apb_cmd_master.sv
// Scoreboard bench for apb_cmd_master: expected responses are queued at command handshake
// and checked in order whenever rsp_valid_o pulses.
module tb_apb_cmd_master;

    localparam int AW = 3;
    localparam int DW = 16;

    logic          PCLK = 1'b0;
    logic          PRESETn;
    logic          cmd_valid, cmd_ready, cmd_write;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic          rsp_valid, rsp_err, busy;
    logic [DW-1:0] rsp_rdata;
    logic [AW-1:0] paddr;
    logic [DW-1:0] pwdata, prdata;
    logic          pwrite, psel, penable, pready;

    apb_cmd_master #(
        .ADDRESSWIDTH(AW), .DATAWIDTH(DW), .FIFO_DEPTH(4), .TIMEOUT_CYCLES(16)
    ) dut (
        .PCLK(PCLK), .PRESETn(PRESETn),
        .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_write_i(cmd_write),
        .cmd_addr_i(cmd_addr), .cmd_wdata_i(cmd_wdata),
        .rsp_valid_o(rsp_valid), .rsp_rdata_o(rsp_rdata), .rsp_err_o(rsp_err), .busy_o(busy),
        .PADDR_o(paddr), .PWDATA_o(pwdata), .PWRITE_o(pwrite), .PSELx_o(psel), .PENABLE_o(penable),
        .PRDATA_i(prdata), .PREADY_i(pready)
    );

    always #5 PCLK = ~PCLK;

    typedef struct packed {
        logic          err;
        logic [DW-1:0] rdata;
    } rsp_t;

    rsp_t sb[$];
    rsp_t mon_exp;
    int   n_cmp = 0;
    int   n_mis = 0;
    int   rsp_cnt = 0;
    int   pen_cnt = 0;
    int   base;
    logic ps [12];
    logic pe [12];
    logic bz [12];

    task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    always @(negedge PCLK) begin
        if (penable === 1'b1) pen_cnt++;
        if (PRESETn && rsp_valid === 1'b1) begin
            rsp_cnt++;
            chk_eq("rsp_expected", sb.size() > 0, 1);
            if (sb.size() > 0) begin
                mon_exp = sb.pop_front();
                chk_eq("rsp_rdata", rsp_rdata, mon_exp.rdata);
                chk_eq("rsp_err", rsp_err, mon_exp.err);
            end
        end
    end

    // Starts at posedge+1, returns at posedge+1 after the handshake edge.
    task automatic send(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d, input logic err_exp);
        rsp_t e;
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = a;
        cmd_wdata = d;
        for (int i = 0; i < 64; i++) begin
            @(negedge PCLK);
            if (cmd_ready) break;
        end
        chk_eq("send_ready", cmd_ready, 1);
        if (cmd_ready) begin
            e.err   = err_exp;
            e.rdata = (wr || err_exp) ? '0 : prdata;
            sb.push_back(e);
        end
        @(posedge PCLK);
        #1 cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp(input int target, input int budget);
        for (int i = 0; i < budget; i++) begin
            @(posedge PCLK);
            if (rsp_cnt >= target) break;
        end
        chk_eq("rsp_count", rsp_cnt, target);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        PRESETn = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
        pready = 1'b1; prdata = '0;
        repeat (2) @(posedge PCLK);
        @(negedge PCLK);
        chk_eq("rst_psel", psel, 0);
        chk_eq("rst_penable", penable, 0);
        chk_eq("rst_paddr", paddr, 0);
        chk_eq("rst_pwdata", pwdata, 0);
        chk_eq("rst_pwrite", pwrite, 0);
        chk_eq("rst_rsp_valid", rsp_valid, 0);
        chk_eq("rst_rsp_rdata", rsp_rdata, 0);
        chk_eq("rst_rsp_err", rsp_err, 0);
        chk_eq("rst_busy", busy, 0);
        chk_eq("rst_cmd_ready", cmd_ready, 1);
        #2 PRESETn = 1'b1;
        @(posedge PCLK);
        #1;

        // Single write, zero wait states
        send(1'b1, 3'd0, 16'h0060, 1'b0);
        @(negedge PCLK); chk_eq("t1_psel_e0", psel, 0);
        @(negedge PCLK);
        chk_eq("t1_psel_e1", psel, 1);
        chk_eq("t1_pen_e1", penable, 0);
        chk_eq("t1_paddr_e1", paddr, 0);
        chk_eq("t1_pwdata_e1", pwdata, 16'h0060);
        chk_eq("t1_pwrite_e1", pwrite, 1);
        @(negedge PCLK);
        chk_eq("t1_psel_e2", psel, 1);
        chk_eq("t1_pen_e2", penable, 1);
        chk_eq("t1_paddr_e2", paddr, 0);
        chk_eq("t1_pwdata_e2", pwdata, 16'h0060);
        chk_eq("t1_pwrite_e2", pwrite, 1);
        @(negedge PCLK);
        chk_eq("t1_rsp_valid_e3", rsp_valid, 1);
        chk_eq("t1_psel_e3", psel, 0);
        chk_eq("t1_pen_e3", penable, 0);
        @(negedge PCLK);
        chk_eq("t1_rsp_valid_e4", rsp_valid, 0);
        chk_eq("t1_busy_e4", busy, 0);
        @(posedge PCLK); #1;

        // Read with three wait states
        prdata = 16'h0ABC; pready = 1'b0; pen_cnt = 0; base = rsp_cnt;
        send(1'b0, 3'd2, 16'h0000, 1'b0);
        repeat (5) @(posedge PCLK);
        #1 pready = 1'b1;
        @(negedge PCLK);
        chk_eq("t2_paddr", paddr, 2);
        chk_eq("t2_pwrite", pwrite, 0);
        chk_eq("t2_pen", penable, 1);
        wait_rsp(base + 1, 20);
        chk_eq("t2_pen_cycles", pen_cnt, 4);

        // Four back-to-back writes
        pready = 1'b1; base = rsp_cnt;
        fork
            begin
                for (int i = 1; i <= 4; i++) send(1'b1, 3'd2, DW'(i), 1'b0);
            end
            begin
                for (int k = 0; k < 12; k++) begin
                    @(negedge PCLK);
                    ps[k] = psel; pe[k] = penable; bz[k] = busy;
                end
            end
        join
        chk_eq("t3_psel_before", ps[1], 0);
        for (int k = 2; k <= 9; k++) begin
            chk_eq($sformatf("t3_psel_%0d", k), ps[k], 1);
            chk_eq($sformatf("t3_pen_%0d", k), pe[k], k % 2);
        end
        chk_eq("t3_psel_after", ps[10], 0);
        chk_eq("t3_busy_last", bz[9], 1);
        chk_eq("t3_busy_end", bz[11], 0);
        @(posedge PCLK); #1;
        wait_rsp(base + 4, 20);

        // Backpressure: FIFO plus one in flight
        pready = 1'b0; prdata = 16'h5A5A; base = rsp_cnt;
        for (int i = 0; i < 5; i++) send(i != 2, AW'(i), DW'(16'h0100 + i), 1'b0);
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 3'd7; cmd_wdata = 16'h0106;
        repeat (3) begin
            @(negedge PCLK);
            chk_eq("t4_ready_full", cmd_ready, 0);
        end
        chk_eq("t4_busy", busy, 1);
        @(posedge PCLK); #1 pready = 1'b1;
        @(posedge PCLK); #1 pready = 1'b0;
        @(negedge PCLK);
        chk_eq("t4_ready_back", cmd_ready, 1);
        if (cmd_ready) sb.push_back('{err: 1'b0, rdata: '0});
        @(posedge PCLK); #1 cmd_valid = 1'b0;
        @(negedge PCLK);
        chk_eq("t4_ready_refull", cmd_ready, 0);
        chk_eq("t4_one_done", rsp_cnt, base + 1);
        @(posedge PCLK); #1 pready = 1'b1;
        wait_rsp(base + 6, 60);

        // Reset during ACCESS with two commands queued
        pready = 1'b0; base = rsp_cnt;
        for (int i = 0; i < 3; i++) send(1'b1, AW'(i + 3), DW'(16'h0200 + i), 1'b0);
        repeat (2) @(posedge PCLK);
        #3 PRESETn = 1'b0;
        #1;
        chk_eq("t5_psel", psel, 0);
        chk_eq("t5_pen", penable, 0);
        chk_eq("t5_paddr", paddr, 0);
        chk_eq("t5_pwdata", pwdata, 0);
        chk_eq("t5_ready", cmd_ready, 1);
        chk_eq("t5_busy", busy, 0);
        sb.delete();
        @(negedge PCLK);
        #2 PRESETn = 1'b1; pready = 1'b1;
        repeat (10) @(posedge PCLK);
        #1;
        chk_eq("t5_no_rsp", rsp_cnt, base);
        chk_eq("t5_psel_after", psel, 0);
        chk_eq("t5_busy_after", busy, 0);

`ifdef APB_TIMEOUT_EN
        // Stuck slave: timeout then a normal write
        pready = 1'b0; pen_cnt = 0; base = rsp_cnt;
        send(1'b1, 3'd5, 16'h0DEF, 1'b1);
        send(1'b1, 3'd6, 16'h0123, 1'b0);
        wait_rsp(base + 1, 40);
        chk_eq("t6_pen_cycles", pen_cnt, 16);
        pready = 1'b1;
        wait_rsp(base + 2, 20);
`endif

        chk_eq("sb_drained", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
